// File: rtl/vdec_hs_depunc.sv
// ============================================================================
// Module   : vdec_hs_depunc (+ vdec_hs_derm puncture lookup)
// Purpose  : depuncturing sequencer for HS-SCCH part1/part2 and AGCH Viterbi
//            paths. Optional frame counter: VDEC_HS_DEPUNC_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vdec_hs_derm (
  input  logic [1:0] mode,
  input  logic [6:0] idx,
  output logic       punc
);
  // Zero-based punctured coded indices for each channel type
  always_comb begin
    punc = 1'b0;
    case (mode)
      2'b00: punc = idx inside {7'd0, 7'd1, 7'd3, 7'd7, 7'd41, 7'd44, 7'd46, 7'd47};
      2'b01: punc = idx inside {[7'd0:7'd7], 7'd11, 7'd13, 7'd14, 7'd23, 7'd41, 7'd47,
                                7'd53, 7'd56, 7'd59, 7'd65, 7'd68, 7'd95, 7'd98,
                                7'd100, 7'd101, [7'd103:7'd110]};
      2'b10: punc = idx inside {7'd0, 7'd1, 7'd4, 7'd5, 7'd6, 7'd10, 7'd11, 7'd13, 7'd14,
                                7'd16, 7'd22, 7'd23, 7'd30, 7'd36, 7'd43, 7'd46, 7'd60,
                                7'd62, 7'd63, 7'd70, 7'd71, 7'd74, 7'd76, 7'd79, 7'd82,
                                7'd83, 7'd84, 7'd86, 7'd87, 7'd89};
      default: punc = 1'b0;
    endcase
  end
endmodule

module vdec_hs_depunc #(
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    hs_mode,
  input  logic          abort,
  input  logic          in_vld,
  input  logic [SW-1:0] in_data,
  output logic          in_rdy,
  output logic          out_vld,
  output logic [SW-1:0] out_sym0,
  output logic [SW-1:0] out_sym1,
  output logic [SW-1:0] out_sym2,
  output logic          out_last,
  input  logic          out_rdy,
  output logic          busy,
  output logic          done,
  output logic [15:0]   dbg_frm_cnt
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_LAST = 2'd2} state_t;

  state_t        r_state;
  logic [1:0]    r_mode;
  logic [6:0]    r_idx;
  logic [1:0]    r_slot;
  logic [SW-1:0] r_asm0;
  logic [SW-1:0] r_asm1;
  logic [6:0]    w_idx_last;
  logic          w_punc;
  logic          w_gate;
  logic          w_adv;
  logic          w_frame_end;
  logic [SW-1:0] w_val;

  vdec_hs_derm u_derm (
    .mode (r_mode),
    .idx  (r_idx),
    .punc (w_punc)
  );

  always_comb begin
    w_idx_last = 7'd47;
    case (r_mode)
      2'b01:   w_idx_last = 7'd110;
      2'b10:   w_idx_last = 7'd89;
      default: w_idx_last = 7'd47;
    endcase
  end

  // Slot 2 may not overwrite a triplet the consumer has not yet taken
  assign w_gate      = (r_slot == 2'd2) && out_vld && !out_rdy;
  assign w_adv       = (r_state == S_RUN) && (w_punc || in_vld) && !w_gate;
  assign in_rdy      = (r_state == S_RUN) && !w_punc && !w_gate;
  assign w_val       = w_punc ? '0 : in_data;
  assign w_frame_end = (r_state == S_LAST) && out_vld && out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mode   <= 2'b00;
      r_idx    <= '0;
      r_slot   <= '0;
      r_asm0   <= '0;
      r_asm1   <= '0;
      out_vld  <= 1'b0;
      out_sym0 <= '0;
      out_sym1 <= '0;
      out_sym2 <= '0;
      out_last <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        r_state  <= S_IDLE;
        r_idx    <= '0;
        r_slot   <= '0;
        r_asm0   <= '0;
        r_asm1   <= '0;
        out_vld  <= 1'b0;
        out_last <= 1'b0;
        busy     <= 1'b0;
      end else begin
        if (out_vld && out_rdy) begin
          out_vld  <= 1'b0;
          out_last <= 1'b0;
        end
        case (r_state)
          S_IDLE: begin
            if (start && hs_mode != 2'b11) begin
              r_state <= S_RUN;
              r_mode  <= hs_mode;
              r_idx   <= '0;
              r_slot  <= '0;
              busy    <= 1'b1;
            end
          end
          S_RUN: begin
            if (w_adv) begin
              r_idx <= r_idx + 7'd1;
              case (r_slot)
                2'd0: begin
                  r_asm0 <= w_val;
                  r_slot <= 2'd1;
                end
                2'd1: begin
                  r_asm1 <= w_val;
                  r_slot <= 2'd2;
                end
                default: begin
                  out_sym0 <= r_asm0;
                  out_sym1 <= r_asm1;
                  out_sym2 <= w_val;
                  out_vld  <= 1'b1;
                  out_last <= (r_idx == w_idx_last);
                  r_slot   <= 2'd0;
                  if (r_idx == w_idx_last) r_state <= S_LAST;
                end
              endcase
            end
          end
          S_LAST: begin
            if (w_frame_end) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef VDEC_HS_DEPUNC_STAT_EN
  logic [15:0] r_frm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frm_cnt <= '0;
    end else if (w_frame_end && !abort) begin
      r_frm_cnt <= r_frm_cnt + 16'd1;
    end
  end

  assign dbg_frm_cnt = r_frm_cnt;
`else
  assign dbg_frm_cnt = 16'd0;
`endif

endmodule

`default_nettype wire
